tofpet_config_engine: RTL and testbench



---
 rtl/tofpet_config_engine.sv | 202 ++++++++++++++++++++
 tb/tb_tofpet_config_engine.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/tofpet_config_engine.sv
// Serial config engine: pops TX words, shifts NBIT bits MSB-first on CFG_SDO/CFG_SCLK, packs CFG_SDI into RX words.
// START to FETCH/BUSY in 1 cycle, CSn low 1 cycle later; empty TX or full RX freezes SCLK low and flags STALLED.
module tofpet_config_engine #(
   parameter int DIV_W  = 4,
   parameter int NBIT_W = 16
) (
   input  logic        CK,
   input  logic        RESETb,
   input  logic [31:0] COMMAND,
   input  logic [31:0] NBIT_INOUT,
   input  logic [31:0] TX_DATA,
   input  logic        TX_EMPTY,
   output logic        TX_RE,
   output logic [31:0] RX_DATA,
   output logic        RX_WE,
   input  logic        RX_FULL,
   output logic        CFG_SCLK,
   output logic        CFG_CSn,
   output logic        CFG_SDO,
   input  logic        CFG_SDI,
   output logic [31:0] STATUS_WORD
);

   typedef enum logic [2:0] {IDLE, FETCH, SETUP, LOW, HIGH, PUSH, HOLD} state_t;

   state_t              state_q;
   logic                cmd0_q;
   logic [1:0]          sdi_sync_q;
   logic [DIV_W-1:0]    div_q;
   logic [DIV_W-1:0]    tim_q;
   logic [NBIT_W-1:0]   nrem_q;
   logic [5:0]          bitcnt_q;
   logic                first_q;
   logic [31:0]         sh_tx_q;
   logic [31:0]         sh_rx_q;
   logic                tx_re_q;
   logic                rx_we_q;
   logic [31:0]         rx_data_q;
   logic                sclk_q;
   logic                csn_q;
   logic                sdo_q;
   logic                busy_q;
   logic                done_q;
   logic                aborted_q;
   logic                stalled_q;

   logic                start_edge;
   logic                abort;
   logic                tim_done;
   logic                unused_cfg;

   assign start_edge = COMMAND[0] & ~cmd0_q;
   assign abort      = COMMAND[1];
   assign tim_done   = (tim_q == div_q);
   assign unused_cfg = ^{COMMAND[31:4+DIV_W], COMMAND[3:2], NBIT_INOUT[31:NBIT_W]};

   always_ff @(posedge CK or negedge RESETb) begin
      if (!RESETb) begin
         state_q    <= IDLE;
         cmd0_q     <= 1'b0;
         sdi_sync_q <= '0;
         div_q      <= '0;
         tim_q      <= '0;
         nrem_q     <= '0;
         bitcnt_q   <= '0;
         first_q    <= 1'b0;
         sh_tx_q    <= '0;
         sh_rx_q    <= '0;
         tx_re_q    <= 1'b0;
         rx_we_q    <= 1'b0;
         rx_data_q  <= '0;
         sclk_q     <= 1'b0;
         csn_q      <= 1'b1;
         sdo_q      <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         aborted_q  <= 1'b0;
         stalled_q  <= 1'b0;
      end else begin
         cmd0_q     <= COMMAND[0];
         sdi_sync_q <= {sdi_sync_q[0], CFG_SDI};
         tx_re_q    <= 1'b0;
         rx_we_q    <= 1'b0;
         if (state_q != IDLE && abort) begin
            // Abandon immediately; a partially assembled RX word is dropped.
            state_q   <= IDLE;
            csn_q     <= 1'b1;
            sclk_q    <= 1'b0;
            sdo_q     <= 1'b0;
            busy_q    <= 1'b0;
            aborted_q <= 1'b1;
         end else begin
            case (state_q)
               IDLE: begin
                  if (start_edge && !abort) begin
                     nrem_q    <= NBIT_INOUT[NBIT_W-1:0];
                     div_q     <= COMMAND[4 +: DIV_W];
                     aborted_q <= 1'b0;
                     stalled_q <= 1'b0;
                     if (NBIT_INOUT[NBIT_W-1:0] == '0) begin
                        done_q <= 1'b1;
                     end else begin
                        done_q  <= 1'b0;
                        busy_q  <= 1'b1;
                        first_q <= 1'b1;
                        state_q <= FETCH;
                     end
                  end
               end
               FETCH: begin
                  sclk_q <= 1'b0;
                  if (TX_EMPTY) begin
                     stalled_q <= 1'b1;
                  end else begin
                     sh_tx_q  <= TX_DATA;
                     sh_rx_q  <= '0;
                     bitcnt_q <= '0;
                     tim_q    <= '0;
                     tx_re_q  <= 1'b1;
                     csn_q    <= 1'b0;
                     if (first_q) begin
                        first_q <= 1'b0;
                        state_q <= SETUP;
                     end else begin
                        sdo_q   <= TX_DATA[31];
                        state_q <= LOW;
                     end
                  end
               end
               SETUP: begin
                  if (tim_done) begin
                     tim_q   <= '0;
                     sdo_q   <= sh_tx_q[31];
                     state_q <= LOW;
                  end else begin
                     tim_q <= tim_q + 1'b1;
                  end
               end
               LOW: begin
                  if (tim_done) begin
                     // SCLK rises now; capture the synchronised SDI at the same edge.
                     tim_q    <= '0;
                     sclk_q   <= 1'b1;
                     sh_rx_q  <= {sh_rx_q[30:0], sdi_sync_q[1]};
                     nrem_q   <= nrem_q - 1'b1;
                     bitcnt_q <= bitcnt_q + 6'd1;
                     state_q  <= HIGH;
                  end else begin
                     tim_q <= tim_q + 1'b1;
                  end
               end
               HIGH: begin
                  if (tim_done) begin
                     tim_q   <= '0;
                     sclk_q  <= 1'b0;
                     sh_tx_q <= {sh_tx_q[30:0], 1'b0};
                     if (bitcnt_q == 6'd32 || nrem_q == '0) begin
                        state_q <= PUSH;
                     end else begin
                        sdo_q   <= sh_tx_q[30];
                        state_q <= LOW;
                     end
                  end else begin
                     tim_q <= tim_q + 1'b1;
                  end
               end
               PUSH: begin
                  if (RX_FULL) begin
                     stalled_q <= 1'b1;
                  end else begin
                     rx_we_q   <= 1'b1;
                     rx_data_q <= sh_rx_q;
                     tim_q     <= '0;
                     state_q   <= (nrem_q == '0) ? HOLD : FETCH;
                  end
               end
               HOLD: begin
                  if (tim_done) begin
                     csn_q   <= 1'b1;
                     sdo_q   <= 1'b0;
                     done_q  <= 1'b1;
                     busy_q  <= 1'b0;
                     state_q <= IDLE;
                  end else begin
                     tim_q <= tim_q + 1'b1;
                  end
               end
               default: state_q <= IDLE;
            endcase
         end
      end
   end

   assign TX_RE       = tx_re_q;
   assign RX_WE       = rx_we_q;
   assign RX_DATA     = rx_data_q;
   assign CFG_SCLK    = sclk_q;
   assign CFG_CSn     = csn_q;
   assign CFG_SDO     = sdo_q;
   assign STATUS_WORD = {16'(nrem_q), 12'd0, stalled_q, aborted_q, done_q, busy_q};

endmodule

// File: tb/tb_tofpet_config_engine.sv
// Directed bench for tofpet_config_engine with SDO looped back to SDI and small TX/RX FIFO models.
module tb_tofpet_config_engine;

   logic        CK = 1'b0;
   logic        RESETb;
   logic [31:0] COMMAND, NBIT_INOUT, TX_DATA, RX_DATA, STATUS_WORD;
   logic        TX_EMPTY, TX_RE, RX_WE, RX_FULL;
   logic        CFG_SCLK, CFG_CSn, CFG_SDO, CFG_SDI;

   always #5 CK = ~CK;

   tofpet_config_engine #(.DIV_W(4), .NBIT_W(16)) dut (
      .CK(CK), .RESETb(RESETb), .COMMAND(COMMAND), .NBIT_INOUT(NBIT_INOUT),
      .TX_DATA(TX_DATA), .TX_EMPTY(TX_EMPTY), .TX_RE(TX_RE),
      .RX_DATA(RX_DATA), .RX_WE(RX_WE), .RX_FULL(RX_FULL),
      .CFG_SCLK(CFG_SCLK), .CFG_CSn(CFG_CSn), .CFG_SDO(CFG_SDO), .CFG_SDI(CFG_SDI),
      .STATUS_WORD(STATUS_WORD)
   );

   logic [31:0] tx_mem [0:7];
   int          tx_cnt;
   int          tx_rd;
   assign TX_EMPTY = (tx_rd >= tx_cnt);
   assign TX_DATA  = tx_mem[tx_rd[2:0]];
   assign CFG_SDI  = CFG_SDO;

   logic        mon_clr;
   logic        sclk_p;
   int          rises, hi_run, hi_min, hi_max, n_tx_re, rx_cnt, we_full, both, csn_lo;
   logic [31:0] rx_got [0:7];

   always @(posedge CK) begin
      if (mon_clr) begin
         sclk_p <= CFG_SCLK; rises <= 0; hi_run <= 0; hi_min <= 255; hi_max <= 0;
         n_tx_re <= 0; rx_cnt <= 0; we_full <= 0; both <= 0; csn_lo <= 0; tx_rd <= 0;
      end else begin
         sclk_p <= CFG_SCLK;
         if (CFG_SCLK && !sclk_p) rises <= rises + 1;
         if (CFG_SCLK) hi_run <= hi_run + 1;
         else if (hi_run != 0) begin
            if (hi_run < hi_min) hi_min <= hi_run;
            if (hi_run > hi_max) hi_max <= hi_run;
            hi_run <= 0;
         end
         if (TX_RE) begin n_tx_re <= n_tx_re + 1; tx_rd <= tx_rd + 1; end
         if (RX_WE) begin rx_got[rx_cnt[2:0]] <= RX_DATA; rx_cnt <= rx_cnt + 1; end
         if (RX_WE && RX_FULL) we_full <= we_full + 1;
         if (TX_RE && RX_WE) both <= both + 1;
         if (!CFG_CSn) csn_lo <= csn_lo + 1;
      end
   end

   int n_asr = 0;
   int n_fail = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_asr++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
      end
   endtask

   task automatic clr_mon();
      @(negedge CK); mon_clr = 1'b1;
      @(negedge CK); mon_clr = 1'b0;
   endtask

   task automatic start(input int n, input int div);
      logic [3:0] d;
      d = div[3:0];
      @(negedge CK);
      NBIT_INOUT = n;
      COMMAND    = {24'd0, d, 4'b0001};
      @(negedge CK);
      COMMAND[0] = 1'b0;
   endtask

   task automatic wait_end(input string nm);
      int k;
      k = 0;
      while (!(STATUS_WORD[1] || STATUS_WORD[2]) && k < 3000) begin
         @(negedge CK); k++;
      end
      chk({nm, "_finish"}, 32'(k < 3000), 32'd1);
      @(negedge CK);
   endtask

   task automatic wait_rises(input string nm, input int target, input logic need_low);
      int k;
      k = 0;
      while (!(rises >= target && (!need_low || !CFG_SCLK)) && k < 3000) begin
         @(negedge CK); k++;
      end
      chk({nm, "_reach"}, 32'(k < 3000), 32'd1);
   endtask

   typedef struct {
      int          n;
      int          div;
      logic [31:0] tx0, tx1, rx0, rx1;
      int          words, nrise, hi;
   } vec_t;
   vec_t vt [6];

   initial begin
      int bad, r0, k;
      vt[0] = '{32, 2, 32'hA5A5_0F0F, 32'h0,         32'hA5A5_0F0F, 32'h0,         1, 32, 3};
      vt[1] = '{40, 2, 32'hDEAD_BEEF, 32'h1200_0000, 32'hDEAD_BEEF, 32'h0000_0012, 2, 40, 3};
      vt[2] = '{8,  3, 32'h3C00_0000, 32'h0,         32'h0000_003C, 32'h0,         1, 8,  4};
      vt[3] = '{1,  5, 32'h8000_0000, 32'h0,         32'h0000_0001, 32'h0,         1, 1,  6};
      vt[4] = '{33, 2, 32'hFFFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0001, 2, 33, 3};
      vt[5] = '{16, 7, 32'hC3A5_0000, 32'h0,         32'h0000_C3A5, 32'h0,         1, 16, 8};

      RESETb = 1'b0; COMMAND = '0; NBIT_INOUT = '0; RX_FULL = 1'b0;
      tx_cnt = 0; mon_clr = 1'b1;
      for (int i = 0; i < 8; i++) tx_mem[i] = '0;
      repeat (3) @(negedge CK);
      chk("rst_csn", CFG_CSn, 1);
      chk("rst_sclk", CFG_SCLK, 0);
      chk("rst_sdo", CFG_SDO, 0);
      chk("rst_tx_re", TX_RE, 0);
      chk("rst_rx_we", RX_WE, 0);
      chk("rst_rx_data", RX_DATA, 0);
      chk("rst_status", STATUS_WORD, 0);
      RESETb = 1'b1;
      mon_clr = 1'b0;

      // Table-driven loopback transfers
      for (int i = 0; i < 6; i++) begin
         clr_mon();
         tx_mem[0] = vt[i].tx0; tx_mem[1] = vt[i].tx1; tx_cnt = vt[i].words;
         start(vt[i].n, vt[i].div);
         wait_end($sformatf("v%0d", i));
         chk($sformatf("v%0d_rx0", i), rx_got[0], vt[i].rx0);
         if (vt[i].words == 2) chk($sformatf("v%0d_rx1", i), rx_got[1], vt[i].rx1);
         chk($sformatf("v%0d_rx_we_cnt", i), rx_cnt, vt[i].words);
         chk($sformatf("v%0d_tx_re_cnt", i), n_tx_re, vt[i].words);
         chk($sformatf("v%0d_sclk_pulses", i), rises, vt[i].nrise);
         chk($sformatf("v%0d_hi_min", i), hi_min, vt[i].hi);
         chk($sformatf("v%0d_hi_max", i), hi_max, vt[i].hi);
         chk($sformatf("v%0d_status", i), STATUS_WORD, 32'h0000_0002);
         chk($sformatf("v%0d_csn_idle", i), CFG_CSn, 1);
         chk($sformatf("v%0d_re_we_overlap", i), both, 0);
      end

      // Start latency: BUSY one cycle after the edge, CSn low the cycle after
      clr_mon();
      tx_mem[0] = 32'h9600_0000; tx_cnt = 1;
      start(8, 2);
      chk("lat_busy_t1", STATUS_WORD[0], 1);
      chk("lat_csn_t1", CFG_CSn, 1);
      @(negedge CK);
      chk("lat_csn_t2", CFG_CSn, 0);
      wait_end("lat");
      chk("lat_rx0", rx_got[0], 32'h0000_0096);

      // TX empty before the second word of N=64
      clr_mon();
      tx_mem[0] = 32'hC0FF_EE11; tx_mem[1] = 32'h2468_ACE0; tx_cnt = 1;
      start(64, 2);
      k = 0;
      while (rx_cnt < 1 && k < 3000) begin @(negedge CK); k++; end
      chk("txst_first_push", 32'(k < 3000), 1);
      bad = 0; r0 = rises;
      repeat (20) begin
         @(negedge CK);
         if (CFG_SCLK || CFG_CSn) bad++;
      end
      chk("txst_pins_frozen", bad, 0);
      chk("txst_no_pulses", rises, r0);
      chk("txst_stalled", STATUS_WORD[3], 1);
      chk("txst_remaining", STATUS_WORD[31:16], 32);
      tx_cnt = 2;
      wait_end("txst");
      chk("txst_rx0", rx_got[0], 32'hC0FF_EE11);
      chk("txst_rx1", rx_got[1], 32'h2468_ACE0);
      chk("txst_rx_cnt", rx_cnt, 2);
      chk("txst_pulses", rises, 64);
      chk("txst_status", STATUS_WORD, 32'h0000_000A);

      // RX full at the first push
      clr_mon();
      RX_FULL = 1'b1;
      tx_mem[0] = 32'h5A5A_C3C3; tx_cnt = 1;
      start(32, 2);
      wait_rises("rxf", 32, 1'b1);
      bad = 0;
      repeat (10) begin
         @(negedge CK);
         if (RX_WE) bad++;
      end
      chk("rxf_no_we_while_full", bad, 0);
      RX_FULL = 1'b0;
      wait_end("rxf");
      chk("rxf_rx_cnt", rx_cnt, 1);
      chk("rxf_rx0", rx_got[0], 32'h5A5A_C3C3);
      chk("rxf_we_full", we_full, 0);
      chk("rxf_status", STATUS_WORD, 32'h0000_000A);

      // ABORT around bit 10, then ABORT together with a START edge
      clr_mon();
      tx_mem[0] = 32'hFFFF_0000; tx_cnt = 1;
      start(32, 2);
      wait_rises("abt", 10, 1'b0);
      COMMAND[1] = 1'b1;
      @(negedge CK);
      chk("abt_csn", CFG_CSn, 1);
      chk("abt_sclk", CFG_SCLK, 0);
      chk("abt_sdo", CFG_SDO, 0);
      chk("abt_flags", STATUS_WORD[3:0], 4'b0100);
      repeat (4) @(negedge CK);
      chk("abt_no_rx_we", rx_cnt, 0);
      tx_mem[1] = 32'h1234_5678; tx_cnt = 2;
      NBIT_INOUT = 32;
      COMMAND = 32'h0000_0023;
      @(negedge CK);
      COMMAND = 32'h0000_0022;
      repeat (2) @(negedge CK);
      chk("abtst_busy", STATUS_WORD[0], 0);
      chk("abtst_csn", CFG_CSn, 1);
      chk("abtst_tx_re", n_tx_re, 1);
      COMMAND = '0;

      // N=0 completes at once with no CSn activity
      clr_mon();
      start(0, 2);
      chk("n0_status", STATUS_WORD, 32'h0000_0002);
      repeat (5) @(negedge CK);
      chk("n0_csn_quiet", csn_lo, 0);
      chk("n0_tx_re", n_tx_re, 0);

      // Reset mid-transfer
      clr_mon();
      tx_mem[0] = 32'hFFFF_FFFF; tx_cnt = 1;
      start(32, 2);
      wait_rises("mrst", 5, 1'b0);
      RESETb = 1'b0;
      #1;
      chk("mrst_csn", CFG_CSn, 1);
      chk("mrst_sclk", CFG_SCLK, 0);
      chk("mrst_sdo", CFG_SDO, 0);
      chk("mrst_status", STATUS_WORD, 0);
      @(negedge CK);
      RESETb = 1'b1;
      repeat (3) @(negedge CK);
      chk("mrst_stays_idle", STATUS_WORD, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_asr, n_fail);
      $finish;
   end

endmodule
